sync_fifo_core: RTL and testbench

- Single-clock, synchronous first-in-first-out buffer: DEPTH entries of DATA_WIDTH bits each.
- Has write/read enables, full/empty status flags and a registered read-data output.
- Used as a general-purpose rate/latency decoupling buffer between two producer/consumer blocks in the same clock domain.

---
 rtl/sync_fifo_core.sv | 79 +++++++
 tb/tb_sync_fifo_core.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with PTR_SIZE+1 bit wrap-bit pointers and a registered read port.
// Flags come only from the registered pointers, so they move one edge after an accepted operation.
module sync_fifo_core #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int PTR_SIZE   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_en,
   input  logic                  read_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  empty,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] data_out
);

   typedef logic [PTR_SIZE:0]     ptr_t;
   typedef logic [PTR_SIZE-1:0]   addr_t;
   typedef logic [DATA_WIDTH-1:0] word_t;

   ptr_t  wr_ptr_q, wr_ptr_d;
   ptr_t  rd_ptr_q, rd_ptr_d;
   word_t data_out_q, data_out_d;
   word_t mem_q [DEPTH];

   logic  wr_accept;
   logic  rd_accept;
   logic  mem_we;
   addr_t wr_addr;
   addr_t rd_addr;

   assign wr_addr = wr_ptr_q[PTR_SIZE-1:0];
   assign rd_addr = rd_ptr_q[PTR_SIZE-1:0];

   // Equal low bits with differing wrap bits means the writer is a full lap ahead.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_addr == rd_addr) && (wr_ptr_q[PTR_SIZE] != rd_ptr_q[PTR_SIZE]);

   assign data_out = data_out_q;

   always_comb begin
      wr_accept  = write_en && !full;
      rd_accept  = read_en && !empty;
      mem_we     = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;

      if (!reset) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         data_out_d = '0;
      end else begin
         if (wr_accept) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
         end
         if (rd_accept) begin
            data_out_d = mem_q[rd_addr];
            rd_ptr_d   = rd_ptr_q + ptr_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
   end

   // Storage is deliberately left uncleared by reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_addr] <= data_in;
      end
   end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Self-checking bench for sync_fifo_core: vector table for reset/fill/drain, scoreboard-checked corner sequences.
module tb_sync_fifo_core;

   logic       clk;
   logic       reset;
   logic       write_en;
   logic       read_en;
   logic [7:0] data_in;
   logic       empty;
   logic       full;
   logic [7:0] data_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst_n;
      logic       we;
      logic       re;
      logic [7:0] din;
      logic       exp_empty;
      logic       exp_full;
      logic [7:0] exp_dout;
   } vec_t;

   vec_t vecs[$];

   // Reference model: stored contents, pending read results, last read value.
   logic [7:0] model_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] model_dout = 8'h00;

   sync_fifo_core #(
      .DATA_WIDTH(8),
      .DEPTH(16),
      .PTR_SIZE(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .write_en(write_en),
      .read_en(read_en),
      .data_in(data_in),
      .empty(empty),
      .full(full),
      .data_out(data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compareVal(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %02h expected %02h", name, got, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic exp_empty, input logic exp_full,
                              input logic [7:0] exp_dout);
      compareVal({name, ".empty"}, {7'd0, empty}, {7'd0, exp_empty});
      compareVal({name, ".full"}, {7'd0, full}, {7'd0, exp_full});
      compareVal({name, ".data_out"}, data_out, exp_dout);
   endtask

   // Drives one cycle, updates the model from its own occupancy, then pops the scoreboard.
   task automatic applyStimulus(input logic rst_n, input logic we, input logic re, input logic [7:0] din);
      logic rd_acc;
      @(negedge clk);
      reset    = rst_n;
      write_en = we;
      read_en  = re;
      data_in  = din;
      rd_acc   = 1'b0;
      if (!rst_n) begin
         model_q.delete();
         exp_q.delete();
         model_dout = 8'h00;
      end else begin
         rd_acc = re && (model_q.size() > 0);
         if (rd_acc) exp_q.push_back(model_q.pop_front());
         if (we && (model_q.size() < 16 || rd_acc == 1'b0 && model_q.size() < 16)) begin
            model_q.push_back(din);
         end
      end
      @(posedge clk);
      #1;
      if (rd_acc) model_dout = exp_q.pop_front();
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, model_q.size() == 0, model_q.size() == 16, model_dout);
   endtask

   initial begin
      reset    = 1'b0;
      write_en = 1'b0;
      read_en  = 1'b0;
      data_in  = 8'h00;

      for (int i = 0; i < 2; i++) vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 8'h00});
      for (int i = 0; i < 16; i++) vecs.push_back('{1'b1, 1'b1, 1'b0, 8'(i), 1'b0, (i == 15), 8'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 8'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 8'h00});
      for (int i = 0; i < 18; i++)
         vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, (i >= 15), 1'b0, (i < 16) ? 8'(i) : 8'h0F});

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst_n, vecs[i].we, vecs[i].re, vecs[i].din);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_dout);
      end

      // Wrap-around: pointers already sit one lap in after the drain.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
         checkModel($sformatf("wrap_rd%0d", i));
      end
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'hA0 + i));
      checkOutput("wrap_full", 1'b0, 1'b1, 8'h39);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
         compareVal($sformatf("wrap_A%0d", i), data_out, 8'(8'hA0 + i));
         checkModel($sformatf("wrap_A%0d_model", i));
      end

      // Simultaneous read/write at occupancy 5, then on an empty FIFO.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'h50 + i));
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 8'(8'h60 + i));
         compareVal($sformatf("simul_occ%0d", i), 8'(model_q.size()), 8'd5);
         checkModel($sformatf("simul%0d", i));
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
         checkModel($sformatf("simul_drain%0d", i));
      end
      checkOutput("simul_empty", 1'b1, 1'b0, 8'h67);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h77);
      checkOutput("rw_on_empty", 1'b0, 1'b0, 8'h67);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("rw_on_empty_rd", 1'b1, 1'b0, 8'h77);

      // Mid-operation reset discards stored entries and clears data_out.
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
      checkModel("pre_reset");
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE);
      checkOutput("mid_reset", 1'b1, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
      checkOutput("post_reset_wr", 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("post_reset_rd", 1'b1, 1'b0, 8'h5A);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
      checkModel("post_reset_hold");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
